// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory:
// access-size encodings, FSM states and counter width.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the sized data memory:
// store byte enables and replication, load extraction and extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Select lanes from the low address bits and extend loads.
  always_comb begin
    byte_en    = 4'b0000;
    store_word = store_data;
    load_data  = word;
    lane_b     = word[{offset, 3'b000} +: 8];
    lane_h     = offset[1] ? word[31:16] : word[15:0];
    unique case (size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << offset;
        store_word = {4{store_data[7:0]}};
        load_data  = {{24{~is_unsigned & lane_b[7]}},
                      lane_b};
      end
      SZ_HALF: begin
        byte_en    = offset[1] ? 4'b1100 : 4'b0011;
        store_word = {2{store_data[15:0]}};
        load_data  = {{16{~is_unsigned & lane_h[15]}},
                      lane_h};
      end
      SZ_WORD: begin
        byte_en = 4'b1111;
      end
      default: begin
        byte_en = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Word-organised data memory with byte/half/word access,
// request validation and a configurable wait-state FSM.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        error,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          store_q;

  logic [31:0] mem [DEPTH];

  logic        req, aligned, in_range, legal;
  logic        accept, reject;
  logic [3:0]  byte_en;
  logic [31:0] store_word, load_data;

  // Decide whether an idle-cycle request is taken or rejected.
  always_comb begin
    req = mem_read | mem_write;
    unique case (mem_size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~address[0];
      SZ_WORD: aligned = address[1:0] == 2'b00;
      default: aligned = 1'b0;
    endcase
    in_range = (address >> (AW + 2)) == 32'd0;
    legal    = ~(mem_read & mem_write) & aligned & in_range;
    accept   = (state == IDLE) & req & legal;
    reject   = (state == IDLE) & req & ~legal;
  end

  // Next state and wait-state countdown.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx   = CNT_W'(WAIT_STATES);
          state_nx = (WAIT_STATES > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Capture the accepted request for use at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= address[AW+1:0];
      wdata_q <= write_data;
      size_q  <= mem_size;
      uns_q   <= mem_unsigned;
      store_q <= mem_write;
    end
  end

  dmem_lane_align u_align (
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .is_unsigned (uns_q),
    .store_data  (wdata_q),
    .word        (mem[addr_q[AW+1:2]]),
    .byte_en     (byte_en),
    .store_word  (store_word),
    .load_data   (load_data)
  );

  // Completion and rejection pulses; load result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready     <= 1'b0;
      error     <= 1'b0;
      read_data <= '0;
    end else begin
      ready <= state == DONE;
      error <= reject;
      if (state == DONE && !store_q) read_data <= load_data;
    end
  end

  // Storage is not reset; stores commit lane-wise on the done edge.
  always_ff @(posedge clk) begin
    if (state == DONE && store_q) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          mem[addr_q[AW+1:2]][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  assign busy = state != IDLE;

endmodule

// File: tb/tb_dmem_sized.sv
// Directed self-checking bench for dmem_sized with
// zero and three wait states.
module tb_dmem_sized;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_unsigned = 1'b0;
  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic        rd3 = 1'b0, wr3 = 1'b0;

  logic [31:0] rdata0, rdata3;
  logic        ready0, error0, busy0;
  logic        ready3, error3, busy3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_sized #(.DEPTH(256), .WAIT_STATES(0)) u0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .write_data   (write_data),
    .mem_read     (rd0),
    .mem_write    (wr0),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .read_data    (rdata0),
    .ready        (ready0),
    .error        (error0),
    .busy         (busy0)
  );

  dmem_sized #(.DEPTH(256), .WAIT_STATES(3)) u3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .write_data   (write_data),
    .mem_read     (rd3),
    .mem_write    (wr3),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .read_data    (rdata3),
    .ready        (ready3),
    .error        (error3),
    .busy         (busy3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [1:0]  sz,
                       input logic        un);
    address      = a;
    write_data   = d;
    mem_size     = sz;
    mem_unsigned = un;
  endtask

  task automatic acc0(input logic rd, input logic wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [1:0]  sz,
                      input logic        un);
    setup(a, d, sz, un);
    rd0 = rd;
    wr0 = wr;
    step;
    rd0 = 1'b0;
    wr0 = 1'b0;
    chk("busy0_inflight", 32'(busy0), 32'd1);
    chk("ready0_early", 32'(ready0), 32'd0);
    step;
    chk("ready0_pulse", 32'(ready0), 32'd1);
    chk("busy0_after", 32'(busy0), 32'd0);
  endtask

  task automatic load0(input string tag,
                       input logic [31:0] a,
                       input logic [1:0]  sz,
                       input logic        un,
                       input logic [31:0] exp);
    acc0(1'b1, 1'b0, a, 32'h0, sz, un);
    chk(tag, rdata0, exp);
  endtask

  task automatic rej0(input string tag,
                      input logic rd, input logic wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [1:0]  sz);
    logic [31:0] prev;
    prev = rdata0;
    setup(a, d, sz, 1'b0);
    rd0 = rd;
    wr0 = wr;
    step;
    rd0 = 1'b0;
    wr0 = 1'b0;
    chk(tag, 32'(error0), 32'd1);
    chk("rej_no_ready", 32'(ready0), 32'd0);
    chk("rej_no_busy", 32'(busy0), 32'd0);
    step;
    chk("rej_err_pulse", 32'(error0), 32'd0);
    chk("rej_rdata_kept", rdata0, prev);
  endtask

  task automatic acc3(input logic rd, input logic wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic        intrude);
    setup(a, d, 2'b10, 1'b0);
    rd3 = rd;
    wr3 = wr;
    step;
    rd3 = 1'b0;
    wr3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busy3_inflight", 32'(busy3), 32'd1);
      chk("ready3_early", 32'(ready3), 32'd0);
      chk("error3_quiet", 32'(error3), 32'd0);
      if (intrude && i == 1) begin
        write_data = 32'hFFFF_FFFF;
        wr3 = 1'b1;
      end
      if (i == 2) wr3 = 1'b0;
      step;
    end
    chk("ready3_pulse", 32'(ready3), 32'd1);
    chk("busy3_after", 32'(busy3), 32'd0);
    step;
    chk("ready3_single", 32'(ready3), 32'd0);
    chk("error3_none", 32'(error3), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_ready0", 32'(ready0), 32'd0);
    chk("rst_error0", 32'(error0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_rdata3", rdata3, 32'h0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    step;
    step;
    rst_n = 1'b1;
    step;

    acc0(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0);
    chk("store_no_rdata", rdata0, 32'h0);
    load0("ld_word", 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);
    step;
    chk("ready0_one_cycle", 32'(ready0), 32'd0);

    acc0(1'b0, 1'b1, 32'h13, 32'h0000_0080, 2'b00, 1'b0);
    load0("ld_sbyte", 32'h13, 2'b00, 1'b0, 32'hFFFF_FF80);
    load0("ld_ubyte", 32'h13, 2'b00, 1'b1, 32'h0000_0080);
    load0("ld_word2", 32'h10, 2'b10, 1'b0, 32'h80AD_BEEF);
    load0("ld_uhalf", 32'h12, 2'b01, 1'b1, 32'h0000_80AD);
    load0("ld_shalf", 32'h12, 2'b01, 1'b0, 32'hFFFF_80AD);
    load0("ld_ubyte1", 32'h11, 2'b00, 1'b1, 32'h0000_00BE);
    load0("ld_sbyte0", 32'h10, 2'b00, 1'b0, 32'hFFFF_FFEF);
    load0("ld_uword", 32'h10, 2'b10, 1'b1, 32'h80AD_BEEF);

    rej0("err_half_mis", 1'b1, 1'b0, 32'h11, 32'h0, 2'b01);
    acc0(1'b0, 1'b1, 32'h0, 32'h1111_1111, 2'b10, 1'b0);
    rej0("err_range", 1'b0, 1'b1, 32'h400, 32'hCAFE_F00D,
         2'b10);
    load0("range_no_write", 32'h0, 2'b10, 1'b0,
          32'h1111_1111);
    rej0("err_both", 1'b1, 1'b1, 32'h10, 32'h0, 2'b10);
    rej0("err_size11", 1'b1, 1'b0, 32'h10, 32'h0, 2'b11);
    rej0("err_word_mis", 1'b1, 1'b0, 32'h12, 32'h0, 2'b10);
    load0("after_errs", 32'h10, 2'b10, 1'b0, 32'h80AD_BEEF);

    acc0(1'b0, 1'b1, 32'h24, 32'hA5A5_5A5A, 2'b10, 1'b0);
    load0("st_ld_same", 32'h24, 2'b10, 1'b0, 32'hA5A5_5A5A);
    acc0(1'b0, 1'b1, 32'h26, 32'h0000_BEEF, 2'b01, 1'b0);
    load0("st_half_hi", 32'h24, 2'b10, 1'b0, 32'hBEEF_5A5A);

    acc3(1'b0, 1'b1, 32'h20, 32'h0BAD_CAFE, 1'b0);
    acc3(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    chk("ws3_load", rdata3, 32'h0BAD_CAFE);

    setup(32'h20, 32'h1234_5678, 2'b10, 1'b0);
    wr3 = 1'b1;
    step;
    wr3 = 1'b0;
    step;
    chk("abort_in_wait", 32'(busy3), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rdata3", rdata3, 32'h0);
    chk("abort_busy3", 32'(busy3), 32'd0);
    chk("abort_ready3", 32'(ready3), 32'd0);
    chk("abort_error3", 32'(error3), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("abort_no_ready", 32'(ready3), 32'd0);
      chk("abort_idle", 32'(busy3), 32'd0);
    end
    acc3(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("abort_no_write", rdata3, 32'h0BAD_CAFE);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_sized.md
DMEM_SIZED -- requirements
Module: dmem_sized

Interface
REQ-001 Parameter DEPTH, default 256: memory depth in 32-bit words; power of two, minimum 4.
REQ-002 Parameter WAIT_STATES, default 0: extra cycles between request acceptance and completion; range 0-15.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port address, input, 32: byte address of the access.
REQ-006 Port write_data, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 Port mem_read, input, 1: load request, sampled only when busy=0.
REQ-008 Port mem_write, input, 1: store request, sampled only when busy=0.
REQ-009 Port mem_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 Port mem_unsigned, input, 1: 1 zero-extends, 0 sign-extends byte/half loads.
REQ-011 Port read_data, output, 32: load result, right-aligned and extended.
REQ-012 Port ready, output, 1: one-cycle completion pulse for an accepted access.
REQ-013 Port error, output, 1: one-cycle pulse for a rejected request.
REQ-014 Port busy, output, 1: high while an access is in flight; new requests are ignored.

Function
REQ-015 FSM states: IDLE, WAIT, DONE. Storage: DEPTH x 32-bit words, 4 byte lanes, little-endian.
REQ-016 IDLE, valid request (exactly one of mem_read/mem_write, legal size, aligned, in range): capture address, size, unsigned flag, write_data and op; load counter with WAIT_STATES; go to WAIT if WAIT_STATES>0, else DONE.
REQ-017 WAIT: decrement counter each cycle; go to DONE when counter reaches 1.
REQ-018 DONE: assert ready for one cycle; store commits only the addressed byte lanes on this edge; load updates read_data on this edge; return to IDLE.
REQ-019 Latency: a request sampled at edge N produces ready high in the cycle after edge N+1+WAIT_STATES.
REQ-020 busy is high in WAIT and DONE, low in IDLE; back-to-back accesses are possible every 2+WAIT_STATES cycles.
REQ-021 Rejected request (both mem_read and mem_write high, mem_size=11, half with address[0]=1, word with address[1:0]!=0, or address>=4*DEPTH): error pulses the next cycle; no memory write; read_data unchanged; FSM stays IDLE.
REQ-022 Byte load: address[1:0] selects the lane. Half load: address[1] selects the lane pair. Result is extended to 32 bits per mem_unsigned; mem_unsigned is ignored for word loads.
REQ-023 read_data holds its value until the next completed load; stores and errors do not change it.
REQ-024 Requests presented while busy=1 are ignored entirely: no error, no queueing.
REQ-025 Word index is address[log2(DEPTH)+1:2]; address bits above that are checked only for the range test.

Reset
REQ-026 When rst_n is low: state=IDLE, counter=0, read_data=0, ready=0, error=0, busy=0, all immediately and asynchronously.
REQ-027 Memory contents are not reset.
REQ-028 Reset during WAIT or DONE, before the commit edge, aborts the access; no memory write occurs and no ready pulse follows.

Structure
REQ-029 Package dmem_pkg holds the mem_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum and the WAIT_STATES counter width.
REQ-030 One sub-module, dmem_lane_align: combinational; generates the byte-enable mask and write-data replication for stores, and performs lane extraction and extension for loads.

Verification
REQ-031 WAIT_STATES=0: word store 0xDEADBEEF @0x10, then word load @0x10 -> ready 2 cycles after each request; read_data=0xDEADBEEF.
REQ-032 Byte store 0x80 @0x13, then loads @0x13: signed byte -> 0xFFFFFF80; unsigned byte -> 0x00000080; word load @0x10 -> 0x80ADBEEF.
REQ-033 Half load @0x11 -> error pulse, read_data unchanged. Word store @0x400 with DEPTH=256 -> error pulse, memory unchanged. mem_read=mem_write=1 -> error pulse.
REQ-034 WAIT_STATES=3: load accepted -> busy high 4 cycles and ready in the 5th cycle after the request; a second request during busy is ignored, with no error and no ready.
REQ-035 Word store 0x12345678 @0x20 with rst_n low during WAIT -> all outputs 0 immediately; a later load @0x20 returns the prior contents.
REQ-036 Store then load with the same address on consecutive accepted slots -> the load returns the newly stored data.
